// File: rtl/axi_datademux.sv
// axi_datademux: splits an interleaved 4:2:0 MCU AXI-Stream into separate Y, Cb and Cr AXI-Streams
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   s_axis_*                            MCU input stream (tuser = first Y0 beat, tlast = last Cr beat)
//   m_axis_y_*                          luma output (tlast per block, tuser on first Y0 beat)
//   m_axis_cb_*, m_axis_cr_*            chroma outputs (tlast per block)
//   err_sync                            one-cycle pulse after a beat that broke MCU framing
module axi_datademux #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_LEN  = 64,
    parameter int Y_BLOCKS   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_y_tdata,
    output logic                  m_axis_y_tvalid,
    input  logic                  m_axis_y_tready,
    output logic                  m_axis_y_tlast,
    output logic                  m_axis_y_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_cb_tdata,
    output logic                  m_axis_cb_tvalid,
    input  logic                  m_axis_cb_tready,
    output logic                  m_axis_cb_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_cr_tdata,
    output logic                  m_axis_cr_tvalid,
    input  logic                  m_axis_cr_tready,
    output logic                  m_axis_cr_tlast,
    output logic                  err_sync
);
    localparam int CW = $clog2(BLOCK_LEN);
    typedef enum logic [1:0] {WAIT_SOF, ST_Y, ST_CB, ST_CR} state_t;
    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [1:0]            r_yblk, w_yblk_nxt;
    logic [DATA_WIDTH-1:0] r_y_data, r_cb_data, r_cr_data;
    logic                  r_y_valid, r_cb_valid, r_cr_valid;
    logic                  r_y_last, r_cb_last, r_cr_last, r_y_user, r_err;
    logic                  w_acc, w_blk_end, w_sof_exp;
    logic                  w_ld_y, w_ld_cb, w_ld_cr, w_ld_last, w_ld_user, w_err;
    // Ready follows only the register slice the current state routes into
    assign s_axis_tready = (r_state == ST_Y)  ? (!r_y_valid  || m_axis_y_tready)  :
                           (r_state == ST_CB) ? (!r_cb_valid || m_axis_cb_tready) :
                           (r_state == ST_CR) ? (!r_cr_valid || m_axis_cr_tready) : 1'b1;
    assign w_acc     = s_axis_tvalid && s_axis_tready;
    assign w_blk_end = r_cnt == CW'(BLOCK_LEN - 1);
    assign w_sof_exp = (r_state == ST_Y) && (r_cnt == '0) && (r_yblk == 2'd0);
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_yblk_nxt  = r_yblk;
        w_ld_y      = 1'b0;
        w_ld_cb     = 1'b0;
        w_ld_cr     = 1'b0;
        w_ld_last   = 1'b0;
        w_ld_user   = 1'b0;
        w_err       = 1'b0;
        if (w_acc) begin
            if (s_axis_tuser) begin
                // A start marker always (re)starts an MCU; only unexpected ones are errors
                w_ld_y      = 1'b1;
                w_ld_user   = 1'b1;
                w_err       = !(r_state == WAIT_SOF || w_sof_exp);
                w_state_nxt = ST_Y;
                w_cnt_nxt   = CW'(1);
                w_yblk_nxt  = 2'd0;
            end else if (w_sof_exp) begin
                w_err       = 1'b1;
                w_state_nxt = WAIT_SOF;
            end else if (r_state != WAIT_SOF) begin
                w_ld_y    = r_state == ST_Y;
                w_ld_cb   = r_state == ST_CB;
                w_ld_cr   = r_state == ST_CR;
                w_ld_last = w_blk_end || s_axis_tlast;
                w_cnt_nxt = w_blk_end ? '0 : r_cnt + CW'(1);
                if (r_state == ST_CR && w_blk_end) begin
                    w_err       = !s_axis_tlast;
                    w_state_nxt = s_axis_tlast ? ST_Y : WAIT_SOF;
                end else if (s_axis_tlast) begin
                    w_err       = 1'b1;
                    w_state_nxt = WAIT_SOF;
                    w_cnt_nxt   = '0;
                    w_yblk_nxt  = 2'd0;
                end else if (w_blk_end && r_state == ST_Y) begin
                    w_yblk_nxt  = (r_yblk == 2'(Y_BLOCKS - 1)) ? 2'd0 : r_yblk + 2'd1;
                    w_state_nxt = (r_yblk == 2'(Y_BLOCKS - 1)) ? ST_CB : ST_Y;
                end else if (w_blk_end && r_state == ST_CB) begin
                    w_state_nxt = ST_CR;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_SOF;
            r_cnt   <= '0;
            r_yblk  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_yblk  <= w_yblk_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_data   <= '0;
            r_y_valid  <= 1'b0;
            r_y_last   <= 1'b0;
            r_y_user   <= 1'b0;
            r_cb_data  <= '0;
            r_cb_valid <= 1'b0;
            r_cb_last  <= 1'b0;
            r_cr_data  <= '0;
            r_cr_valid <= 1'b0;
            r_cr_last  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_ld_y) begin
                r_y_data  <= s_axis_tdata;
                r_y_valid <= 1'b1;
                r_y_last  <= w_ld_last;
                r_y_user  <= w_ld_user;
            end else if (m_axis_y_tready) begin
                r_y_valid <= 1'b0;
            end
            if (w_ld_cb) begin
                r_cb_data  <= s_axis_tdata;
                r_cb_valid <= 1'b1;
                r_cb_last  <= w_ld_last;
            end else if (m_axis_cb_tready) begin
                r_cb_valid <= 1'b0;
            end
            if (w_ld_cr) begin
                r_cr_data  <= s_axis_tdata;
                r_cr_valid <= 1'b1;
                r_cr_last  <= w_ld_last;
            end else if (m_axis_cr_tready) begin
                r_cr_valid <= 1'b0;
            end
        end
    end
    assign m_axis_y_tdata   = r_y_data;
    assign m_axis_y_tvalid  = r_y_valid;
    assign m_axis_y_tlast   = r_y_last;
    assign m_axis_y_tuser   = r_y_user;
    assign m_axis_cb_tdata  = r_cb_data;
    assign m_axis_cb_tvalid = r_cb_valid;
    assign m_axis_cb_tlast  = r_cb_last;
    assign m_axis_cr_tdata  = r_cr_data;
    assign m_axis_cr_tvalid = r_cr_valid;
    assign m_axis_cr_tlast  = r_cr_last;
    assign err_sync         = r_err;
endmodule

// File: tb/tb_axi_datademux.sv
// tb_axi_datademux: table-driven, hand-sequenced and randomized bench for axi_datademux
module tb_axi_datademux;
    localparam int DW  = 32;
    localparam int BL  = 64;
    localparam int YB  = 4;
    localparam int MCU = (YB + 2) * BL;

    typedef struct {logic [DW-1:0] d; logic u; logic l;} beat_t;
    typedef struct {logic [DW-1:0] d; logic l; logic u;} out_t;
    typedef struct {
        int garbage; int n_mcu; int kind; int pos; int mode;
        int ey; int ecb; int ecr; int eerr; int eylast; int euser;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
    logic [DW-1:0] m_axis_y_tdata, m_axis_cb_tdata, m_axis_cr_tdata;
    logic          m_axis_y_tvalid, m_axis_y_tlast, m_axis_y_tuser;
    logic          m_axis_cb_tvalid, m_axis_cb_tlast, m_axis_cr_tvalid, m_axis_cr_tlast;
    logic          m_axis_y_tready = 1'b1, m_axis_cb_tready = 1'b1, m_axis_cr_tready = 1'b1;
    logic          err_sync;

    int    n_tests = 0, n_fail = 0;
    int    mode = 0, drops = 0, k_data = 0, m_pos = -1, exp_err = 0, got_err = 0;
    logic  gaps = 1'b0;
    beat_t stim[$];
    out_t  exp_y[$], exp_cb[$], exp_cr[$], got_y[$], got_cb[$], got_cr[$];
    vec_t  vecs[9];

    axi_datademux #(.DATA_WIDTH(DW), .BLOCK_LEN(BL), .Y_BLOCKS(YB)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_y_tdata(m_axis_y_tdata), .m_axis_y_tvalid(m_axis_y_tvalid), .m_axis_y_tready(m_axis_y_tready),
        .m_axis_y_tlast(m_axis_y_tlast), .m_axis_y_tuser(m_axis_y_tuser),
        .m_axis_cb_tdata(m_axis_cb_tdata), .m_axis_cb_tvalid(m_axis_cb_tvalid), .m_axis_cb_tready(m_axis_cb_tready),
        .m_axis_cb_tlast(m_axis_cb_tlast),
        .m_axis_cr_tdata(m_axis_cr_tdata), .m_axis_cr_tvalid(m_axis_cr_tvalid), .m_axis_cr_tready(m_axis_cr_tready),
        .m_axis_cr_tlast(m_axis_cr_tlast),
        .err_sync(err_sync)
    );

    initial forever #5 clk = ~clk;

    // Sink readiness: 0 all ready, 1 Cb random, 2 all random, 3 Cb/Cr random with Y always ready
    initial forever begin
        @(negedge clk);
        m_axis_y_tready  = (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
        m_axis_cb_tready = (mode != 0) ? 1'($urandom_range(1)) : 1'b1;
        m_axis_cr_tready = (mode >= 2) ? 1'($urandom_range(1)) : 1'b1;
    end

    // Output monitor: records every completed handshake and each err_sync cycle
    initial forever begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (m_axis_y_tvalid && m_axis_y_tready) got_y.push_back('{m_axis_y_tdata, m_axis_y_tlast, m_axis_y_tuser});
            if (m_axis_cb_tvalid && m_axis_cb_tready) got_cb.push_back('{m_axis_cb_tdata, m_axis_cb_tlast, 1'b0});
            if (m_axis_cr_tvalid && m_axis_cr_tready) got_cr.push_back('{m_axis_cr_tdata, m_axis_cr_tlast, 1'b0});
            if (err_sync) got_err++;
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: tracks the position inside an MCU (-1 = waiting for a start marker)
    task automatic model(input beat_t b);
        int blk;
        out_t o;
        if (b.u) begin
            if (m_pos > 0) exp_err++;
            exp_y.push_back('{b.d, 1'b0, 1'b1});
            m_pos = 1;
        end else if (m_pos == 0) begin
            exp_err++;
            m_pos = -1;
        end else if (m_pos > 0) begin
            blk = m_pos / BL;
            o = '{b.d, (m_pos % BL == BL - 1) || b.l, 1'b0};
            if (blk < YB) exp_y.push_back(o);
            else if (blk == YB) exp_cb.push_back(o);
            else exp_cr.push_back(o);
            if (m_pos == MCU - 1) begin
                if (!b.l) exp_err++;
                m_pos = b.l ? 0 : -1;
            end else if (b.l) begin
                exp_err++;
                m_pos = -1;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic send(input beat_t b);
        logic acc;
        acc = 1'b0;
        @(negedge clk);
        while (gaps && $urandom_range(3) == 0) @(negedge clk);
        s_axis_tdata = b.d;
        s_axis_tuser = b.u;
        s_axis_tlast = b.l;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            #2;
            acc = s_axis_tready;
            if (!acc) drops++;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1 s_axis_tvalid = 1'b0;
        if (acc) model(b);
        else begin
            n_tests++;
            n_fail++;
            $display("FAIL send_accept: got 0, expected 1 (data %0d)", b.d);
        end
    endtask

    task automatic push_beat(input logic u, input logic l);
        stim.push_back('{DW'(k_data), u, l});
        k_data++;
    endtask

    // kind: 0 clean, 1 tuser at pos, 2 tlast at pos, 3 last Cr without tlast,
    //       4 tuser=0 beat at the expected MCU start, 5 tuser+tlast at pos
    task automatic build(input vec_t v);
        logic l;
        stim.delete();
        k_data = 0;
        for (int g = 0; g < v.garbage; g++) push_beat(1'b0, 1'b0);
        for (int m = 0; m < v.n_mcu; m++) begin
            if (m == 0 && (v.kind == 1 || v.kind == 5)) begin
                for (int b = 0; b < v.pos; b++) push_beat(b == 0, 1'b0);
                push_beat(1'b1, v.kind == 5);
                for (int c = 1; c < MCU; c++) push_beat(1'b0, c == MCU - 1);
            end else begin
                for (int b = 0; b < MCU; b++) begin
                    l = (b == MCU - 1);
                    if (m == 0 && v.kind == 2 && b == v.pos) l = 1'b1;
                    if (m == 0 && v.kind == 3 && b == MCU - 1) l = 1'b0;
                    push_beat(b == 0, l);
                end
            end
            if (m == 0 && v.kind == 4) push_beat(1'b0, 1'b0);
        end
    endtask

    task automatic run_stim();
        foreach (stim[i]) send(stim[i]);
    endtask

    task automatic drain(input string nm);
        logic done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            #4;
            done = !(m_axis_y_tvalid || m_axis_cb_tvalid || m_axis_cr_tvalid);
        end
        check({nm, "_drained"}, done, 1);
    endtask

    task automatic clear_all();
        exp_y.delete(); exp_cb.delete(); exp_cr.delete();
        got_y.delete(); got_cb.delete(); got_cr.delete();
        m_pos = -1;
        exp_err = 0;
        got_err = 0;
        drops = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cmp_q(input string nm, input out_t g[$], input out_t e[$]);
        int bad;
        bad = -1;
        check({nm, "_len"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++)
            if (bad < 0 && (g[i].d !== e[i].d || g[i].l !== e[i].l || g[i].u !== e[i].u)) bad = i;
        check({nm, "_first_bad_idx"}, bad, -1);
    endtask

    task automatic cmp_all(input string nm);
        cmp_q({nm, "_y"}, got_y, exp_y);
        cmp_q({nm, "_cb"}, got_cb, exp_cb);
        cmp_q({nm, "_cr"}, got_cr, exp_cr);
        check({nm, "_err_pulses"}, got_err, exp_err);
    endtask

    initial begin
        int ylast, yuser;
        string nm;
        //            garb mcu kind pos mode   y   cb   cr err ylast user
        vecs[0] = '{0,  1, 0, 0,   0, 256,  64,  64, 0,  4, 1};
        vecs[1] = '{10, 1, 0, 0,   0, 256,  64,  64, 0,  4, 1};
        vecs[2] = '{0,  1, 1, 100, 0, 356,  64,  64, 1,  5, 2};
        vecs[3] = '{0,  2, 2, 300, 0, 512, 109,  64, 1,  8, 2};
        vecs[4] = '{0,  3, 0, 0,   1, 768, 192, 192, 0, 12, 3};
        vecs[5] = '{0,  2, 3, 0,   0, 512, 128, 128, 1,  8, 2};
        vecs[6] = '{0,  2, 4, 0,   0, 512, 128, 128, 1,  8, 2};
        vecs[7] = '{0,  1, 5, 50,  0, 306,  64,  64, 1,  4, 2};
        vecs[8] = '{0,  2, 0, 0,   2, 512, 128, 128, 0,  8, 2};

        #1 rst_n = 1'b0;
        #3;
        check("rst_y_tvalid", m_axis_y_tvalid, 0);
        check("rst_cb_tvalid", m_axis_cb_tvalid, 0);
        check("rst_cr_tvalid", m_axis_cr_tvalid, 0);
        check("rst_y_tlast", m_axis_y_tlast, 0);
        check("rst_y_tuser", m_axis_y_tuser, 0);
        check("rst_cb_tlast", m_axis_cb_tlast, 0);
        check("rst_cr_tlast", m_axis_cr_tlast, 0);
        check("rst_err_sync", err_sync, 0);
        check("rst_y_tdata", m_axis_y_tdata, 0);
        check("rst_cb_tdata", m_axis_cb_tdata, 0);
        check("rst_cr_tdata", m_axis_cr_tdata, 0);
        check("rst_s_tready", s_axis_tready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 9; r++) begin
            nm = $sformatf("row%0d", r);
            do_reset();
            clear_all();
            mode = vecs[r].mode;
            gaps = vecs[r].mode != 0;
            build(vecs[r]);
            drops = 0;
            run_stim();
            drain(nm);
            cmp_all(nm);
            ylast = 0;
            yuser = 0;
            foreach (got_y[i]) begin
                ylast += int'(got_y[i].l);
                yuser += int'(got_y[i].u);
            end
            check({nm, "_y_count"}, got_y.size(), vecs[r].ey);
            check({nm, "_cb_count"}, got_cb.size(), vecs[r].ecb);
            check({nm, "_cr_count"}, got_cr.size(), vecs[r].ecr);
            check({nm, "_err_count"}, got_err, vecs[r].eerr);
            check({nm, "_y_tlasts"}, ylast, vecs[r].eylast);
            check({nm, "_y_tusers"}, yuser, vecs[r].euser);
            if (vecs[r].mode == 0) check({nm, "_tready_low_cycles"}, drops, 0);
        end

        // Reset while Y holds a beat mid-MCU, then a clean MCU afterwards
        do_reset();
        clear_all();
        mode = 0;
        gaps = 1'b0;
        build(vecs[0]);
        for (int i = 0; i <= 150; i++) send(stim[i]);
        check("midrst_y_valid_before", m_axis_y_tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_y_tvalid", m_axis_y_tvalid, 0);
        check("midrst_cb_tvalid", m_axis_cb_tvalid, 0);
        check("midrst_cr_tvalid", m_axis_cr_tvalid, 0);
        repeat (2) @(negedge clk);
        clear_all();
        rst_n = 1'b1;
        run_stim();
        drain("midrst");
        cmp_all("midrst");
        check("midrst_first_y_tuser", (got_y.size() > 0) ? int'(got_y[0].u) : 0, 1);

        // Randomized framing corruption with stalling chroma sinks
        do_reset();
        clear_all();
        mode = 3;
        gaps = 1'b1;
        stim.delete();
        k_data = 1000;
        for (int m = 0; m < 8; m++) begin
            if ($urandom_range(3) == 0)
                for (int g = 0; g < int'($urandom_range(5)); g++) push_beat(1'b0, 1'b0);
            for (int b = 0; b < MCU; b++)
                push_beat((b == 0) ^ ($urandom_range(399) == 0), (b == MCU - 1) ^ ($urandom_range(399) == 0));
        end
        run_stim();
        drain("rand");
        cmp_all("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
